spi_slave_rx_tx: RTL and testbench
==================================

Name: spi_slave_rx_tx

Overview:
- SPI responder: the far end of the SPI master link. Serves an external master in mode 0 (CPOL=0, CPHA=0), 8-bit frames, MSB first.
- Oversamples SCLK/MOSI/CS_n on the 10 MHz system clock.
- Receives bytes into rx_data_o and shifts a buffered byte out on MISO.
- Sits in the peripheral tree beside the SPI master and is driven from the processor bus wrapper.

Parameters:
- DATA_W, 8, frame width in bits.
- SYNC_STAGES, 2, flip-flop stages on the SCLK, MOSI and CS_n inputs.
- DUMMY_BYTE, 8'h00, byte shifted out when the TX buffer is empty at frame load.

Ports:
- clk_i  input  1  system clock, 10 MHz
- rst_i  input  1  reset, asynchronous, active-low
- sclk_i  input  1  SPI clock from master, asynchronous
- cs_ni  input  1  chip select from master, active-low, asynchronous
- mosi_i  input  1  master-out data, asynchronous
- miso_o  output  1  slave-out data
- miso_oe_o  output  1  MISO output enable, high while selected
- tx_data_i  input  DATA_W  byte to send in a later frame
- tx_valid_i  input  1  tx_data_i valid
- tx_ready_o  output  1  TX buffer empty, write accepted
- rx_data_o  output  DATA_W  last complete received byte
- rx_valid_o  output  1  one-cycle pulse, rx_data_o updated
- tx_underrun_o  output  1  one-cycle pulse, DUMMY_BYTE loaded

Behaviour:
- Reset (rst_i low, asynchronous):
  - Outputs: miso_o=0, miso_oe_o=0, rx_data_o=0, rx_valid_o=0, tx_underrun_o=0, tx_ready_o=1.
  - Internal: sync chains set to sclk=0, cs_n=1, mosi=0; state IDLE; bit_cnt=DATA_W-1.
  - Reset mid-frame discards everything, including the TX buffer.
- Input constraints:
  - SCLK high and low phases each ≥ 4 clk_i cycles (SCLK ≤ 1.25 MHz).
  - CS_n fall to first SCLK rise ≥ SYNC_STAGES+3 clk_i cycles.
- Synchronisation: sclk_s, cs_s, mosi_s are the outputs of the SYNC_STAGES chains. rise/fall are single-cycle pulses from sclk_s versus its previous value. All decisions use the synced signals only.
- TX buffer (one entry):
  - tx_ready_o = ~tx_full.
  - Write when tx_valid_i & tx_ready_o.
  - Freed when its byte is loaded into the shifter.
  - Load and write in the same cycle with the buffer empty: the load sees empty (DUMMY_BYTE, underrun pulse) and the write lands in the buffer.
- State IDLE (cs_s=1):
  - miso_oe_o=0, miso_o=0, bit_cnt=DATA_W-1.
  - Falling edge of cs_s: load tx_shift from the buffer, or DUMMY_BYTE plus tx_underrun_o pulse if empty. Drive miso_o=tx_shift[MSB] in the same cycle. Go to ACTIVE.
- State ACTIVE (cs_s=0):
  - miso_oe_o=1, miso_o=tx_shift[DATA_W-1].
  - On rise:
    - rx_shift <= {rx_shift[DATA_W-2:0], mosi_s}; bit_cnt decrements.
    - When bit_cnt==0: next cycle rx_data_o <= completed byte and rx_valid_o=1 for exactly one cycle. bit_cnt wraps to DATA_W-1 and reload_pend is set.
  - On fall:
    - If reload_pend: load the next TX byte (buffer or DUMMY_BYTE plus underrun pulse) and clear reload_pend.
    - Else tx_shift shifts left by 1.
  - Back-to-back frames without CS_n deassertion are supported indefinitely.
- CS_n rises mid-frame (bit_cnt≠DATA_W-1 or reload_pend=0 after at least one rise):
  - Frame is aborted: no rx_valid_o, partial rx_shift discarded, return to IDLE.
  - A TX buffer entry not yet loaded stays valid for the next frame.
- CS_n rises exactly after the 8th rise: the byte is already delivered. Return to IDLE; reload_pend is cleared and no load occurs.
- SCLK edges while in IDLE are ignored.
- rx_valid_o has no back-pressure: software must read within one frame time; a later byte overwrites rx_data_o.
- Latency: MOSI bit sampled SYNC_STAGES+1 clk_i cycles after the SCLK rise pin edge. MISO changes SYNC_STAGES+1 cycles after the SCLK fall pin edge.

Decomposition:
- Package spi_pkg:
  - typedef enum logic {IDLE, ACTIVE} spi_slv_state_e;
  - localparam DUMMY_BYTE default;
  - shared SPI_DATA_W=8 constant, also used by the master.
- Sub-module spi_sync_edge: per-input SYNC_STAGES synchroniser, plus rise/fall pulse generation on SCLK and fall detection on CS_n. Instantiated once, with a 3-bit input vector.

Test Plan:
- Reset release, then write tx 8'hA5 (tx_ready_o drops to 0). Master sends 8'h3C at 1.25 MHz → rx_data_o=8'h3C with a single rx_valid_o pulse; MISO bits captured by the master = 8'hA5; tx_ready_o returns to 1 after load.
- Empty TX buffer, frame 8'hFF → MISO=8'h00, one tx_underrun_o pulse at CS_n fall, rx_data_o=8'hFF.
- Two back-to-back frames 8'h12, 8'h34 under continuous CS_n low, tx 8'hC3 then 8'h5A written in time → two rx_valid_o pulses with 8'h12 then 8'h34; MISO 8'hC3 then 8'h5A.
- Abort: CS_n rises after 5 SCLK rises with tx 8'h81 buffered → no rx_valid_o; next full frame outputs MISO=8'h81 (the buffer entry was not consumed), rx correct.
- rst_i asserted after 3 bits of a frame → all outputs at reset values immediately (async); next frame after release behaves as a clean first frame.
- SCLK toggling with CS_n high, then tx write coinciding with the CS_n-fall load cycle → no rx_valid_o during idle toggling; the coincident frame sends DUMMY with an underrun pulse and the written byte goes out in the following frame.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared SPI definitions: frame width, slave FSM states and synchroniser bit map.
package spi_pkg;

    localparam int unsigned SPI_DATA_W      = 8;
    localparam int unsigned SPI_SYNC_STAGES = 2;
    localparam logic [SPI_DATA_W-1:0] SPI_DUMMY_BYTE = 8'h00;

    // Bit positions inside the synchroniser input vector
    localparam int unsigned SYNC_W    = 3;
    localparam int unsigned SYNC_SCLK = 0;
    localparam int unsigned SYNC_CS   = 1;
    localparam int unsigned SYNC_MOSI = 2;
    localparam logic [SYNC_W-1:0] SYNC_RST = 3'b010;

    typedef enum logic {IDLE, ACTIVE} spi_slv_state_e;

endpackage

// File: rtl/spi_slave_rx_tx_if.sv
// Pin and processor-side signals of the SPI responder.
interface spi_slave_rx_tx_if #(
    parameter int unsigned DATA_W = spi_pkg::SPI_DATA_W
);
    logic              sclk_i;
    logic              cs_ni;
    logic              mosi_i;
    logic              miso_o;
    logic              miso_oe_o;
    logic [DATA_W-1:0] tx_data_i;
    logic              tx_valid_i;
    logic              tx_ready_o;
    logic [DATA_W-1:0] rx_data_o;
    logic              rx_valid_o;
    logic              tx_underrun_o;

    modport slave (
        input  sclk_i, cs_ni, mosi_i, tx_data_i, tx_valid_i,
        output miso_o, miso_oe_o, tx_ready_o, rx_data_o, rx_valid_o, tx_underrun_o
    );

    modport master (
        output sclk_i, cs_ni, mosi_i, tx_data_i, tx_valid_i,
        input  miso_o, miso_oe_o, tx_ready_o, rx_data_o, rx_valid_o, tx_underrun_o
    );
endinterface

// File: rtl/spi_sync_edge.sv
// Multi-stage synchroniser for SCLK/CS_n/MOSI with SCLK edge and CS_n fall pulses.
module spi_sync_edge
    import spi_pkg::*;
#(
    parameter int unsigned STAGES = SPI_SYNC_STAGES
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [SYNC_W-1:0] async_i,
    output logic              cs_s_o,
    output logic              mosi_s_o,
    output logic              sclk_rise_c,
    output logic              sclk_fall_c,
    output logic              cs_fall_c
);

    logic [STAGES-1:0][SYNC_W-1:0] sync_q, sync_d;
    logic                          sclk_prev_q, sclk_prev_d;
    logic                          cs_prev_q, cs_prev_d;
    logic [SYNC_W-1:0]             sync_s;

    always_comb begin
        sync_d[0] = async_i;
        for (int unsigned s = 1; s < STAGES; s++) begin
            sync_d[s] = sync_q[s-1];
        end
        sync_s      = sync_q[STAGES-1];
        sclk_prev_d = sync_s[SYNC_SCLK];
        cs_prev_d   = sync_s[SYNC_CS];
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            sync_q      <= {STAGES{SYNC_RST}};
            sclk_prev_q <= 1'b0;
            cs_prev_q   <= 1'b1;
        end else begin
            sync_q      <= sync_d;
            sclk_prev_q <= sclk_prev_d;
            cs_prev_q   <= cs_prev_d;
        end
    end

    assign cs_s_o      = sync_s[SYNC_CS];
    assign mosi_s_o    = sync_s[SYNC_MOSI];
    assign sclk_rise_c =  sync_s[SYNC_SCLK] & ~sclk_prev_q;
    assign sclk_fall_c = ~sync_s[SYNC_SCLK] &  sclk_prev_q;
    assign cs_fall_c   = ~sync_s[SYNC_CS]   &  cs_prev_q;

endmodule

// File: rtl/spi_slave_rx_tx.sv
// SPI mode-0 responder: oversampled MOSI receive, one-entry TX buffer feeding MISO.
module spi_slave_rx_tx
    import spi_pkg::*;
#(
    parameter int unsigned       DATA_W      = SPI_DATA_W,
    parameter int unsigned       SYNC_STAGES = SPI_SYNC_STAGES,
    parameter logic [DATA_W-1:0] DUMMY_BYTE  = DATA_W'(SPI_DUMMY_BYTE)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    spi_slave_rx_tx_if.slave    bus
);

    localparam int unsigned           CNT_W   = $clog2(DATA_W);
    localparam logic [CNT_W-1:0]      CNT_MAX = CNT_W'(DATA_W - 1);

    spi_slv_state_e    state_q, state_d;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic              reload_pend_q, reload_pend_d;
    logic [DATA_W-1:0] tx_shift_q, tx_shift_d;
    logic [DATA_W-1:0] rx_shift_q, rx_shift_d;
    logic [DATA_W-1:0] tx_buf_q, tx_buf_d;
    logic              tx_ready_q, tx_ready_d;
    logic [DATA_W-1:0] rx_data_q, rx_data_d;
    logic              rx_valid_q, rx_valid_d;
    logic              underrun_q, underrun_d;
    logic              miso_q, miso_d;
    logic              miso_oe_q, miso_oe_d;

    logic [SYNC_W-1:0] sync_in_c;
    logic              cs_s, mosi_s;
    logic              sclk_rise_c, sclk_fall_c, cs_fall_c;
    logic              load_c;

    always_comb begin
        sync_in_c            = '0;
        sync_in_c[SYNC_SCLK] = bus.sclk_i;
        sync_in_c[SYNC_CS]   = bus.cs_ni;
        sync_in_c[SYNC_MOSI] = bus.mosi_i;
    end

    spi_sync_edge #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .async_i     (sync_in_c),
        .cs_s_o      (cs_s),
        .mosi_s_o    (mosi_s),
        .sclk_rise_c (sclk_rise_c),
        .sclk_fall_c (sclk_fall_c),
        .cs_fall_c   (cs_fall_c)
    );

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q       <= IDLE;
            bit_cnt_q     <= CNT_MAX;
            reload_pend_q <= 1'b0;
            tx_shift_q    <= '0;
            rx_shift_q    <= '0;
            tx_buf_q      <= '0;
            tx_ready_q    <= 1'b1;
            rx_data_q     <= '0;
            rx_valid_q    <= 1'b0;
            underrun_q    <= 1'b0;
            miso_q        <= 1'b0;
            miso_oe_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            bit_cnt_q     <= bit_cnt_d;
            reload_pend_q <= reload_pend_d;
            tx_shift_q    <= tx_shift_d;
            rx_shift_q    <= rx_shift_d;
            tx_buf_q      <= tx_buf_d;
            tx_ready_q    <= tx_ready_d;
            rx_data_q     <= rx_data_d;
            rx_valid_q    <= rx_valid_d;
            underrun_q    <= underrun_d;
            miso_q        <= miso_d;
            miso_oe_q     <= miso_oe_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        bit_cnt_d     = bit_cnt_q;
        reload_pend_d = reload_pend_q;
        tx_shift_d    = tx_shift_q;
        rx_shift_d    = rx_shift_q;
        tx_buf_d      = tx_buf_q;
        tx_ready_d    = tx_ready_q;
        rx_data_d     = rx_data_q;
        rx_valid_d    = 1'b0;
        underrun_d    = 1'b0;
        load_c        = 1'b0;

        case (state_q)
            IDLE: begin
                bit_cnt_d     = CNT_MAX;
                reload_pend_d = 1'b0;
                rx_shift_d    = '0;
                if (cs_fall_c) begin
                    load_c  = 1'b1;
                    state_d = ACTIVE;
                end
            end
            ACTIVE: begin
                if (cs_s) begin
                    // Deselect: partial frame dropped, unloaded TX entry kept
                    state_d       = IDLE;
                    bit_cnt_d     = CNT_MAX;
                    reload_pend_d = 1'b0;
                end else if (sclk_rise_c) begin
                    rx_shift_d = {rx_shift_q[DATA_W-2:0], mosi_s};
                    if (bit_cnt_q == '0) begin
                        bit_cnt_d     = CNT_MAX;
                        reload_pend_d = 1'b1;
                        rx_data_d     = rx_shift_d;
                        rx_valid_d    = 1'b1;
                    end else begin
                        bit_cnt_d = bit_cnt_q - CNT_W'(1);
                    end
                end else if (sclk_fall_c) begin
                    if (reload_pend_q) begin
                        load_c        = 1'b1;
                        reload_pend_d = 1'b0;
                    end else begin
                        tx_shift_d = tx_shift_q << 1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Load sees the buffer as it was before any same-cycle write
        if (load_c) begin
            if (!tx_ready_q) begin
                tx_shift_d = tx_buf_q;
                tx_ready_d = 1'b1;
            end else begin
                tx_shift_d = DUMMY_BYTE;
                underrun_d = 1'b1;
            end
        end

        if (bus.tx_valid_i && tx_ready_q) begin
            tx_buf_d   = bus.tx_data_i;
            tx_ready_d = 1'b0;
        end

        miso_oe_d = (state_d == ACTIVE);
        miso_d    = miso_oe_d & tx_shift_d[DATA_W-1];
    end

    assign bus.miso_o        = miso_q;
    assign bus.miso_oe_o     = miso_oe_q;
    assign bus.tx_ready_o    = tx_ready_q;
    assign bus.rx_data_o     = rx_data_q;
    assign bus.rx_valid_o    = rx_valid_q;
    assign bus.tx_underrun_o = underrun_q;

endmodule

// File: tb/tb_spi_slave_rx_tx.sv
// Scoreboard bench for spi_slave_rx_tx: a mode-0 master model drives frames, a monitor checks outputs.
module tb_spi_slave_rx_tx;
    import spi_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #50 clk = ~clk;

    spi_slave_rx_tx_if bus_if ();

    spi_slave_rx_tx dut (
        .clk_i (clk),
        .rst_i (rst_n),
        .bus   (bus_if)
    );

    int checks = 0;
    int errors = 0;

    logic [7:0] rx_exp[$];
    logic [7:0] miso_exp[$];
    logic [7:0] miso_obs[$];
    bit         urun_exp[$];

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: compare whatever the DUT presents against the expectation queues
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (bus_if.rx_valid_o) begin
                    if (rx_exp.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL rx_valid unexpected: got data %h expected no pulse at %0t",
                                 bus_if.rx_data_o, $time);
                    end else begin
                        check8("rx_data", bus_if.rx_data_o, rx_exp.pop_front());
                    end
                end
                if (bus_if.tx_underrun_o) begin
                    checks++;
                    if (urun_exp.size() == 0) begin
                        errors++;
                        $display("FAIL tx_underrun unexpected: got pulse expected none at %0t", $time);
                    end else begin
                        void'(urun_exp.pop_front());
                    end
                end
                while (miso_obs.size() > 0 && miso_exp.size() > 0) begin
                    check8("miso_byte", miso_obs.pop_front(), miso_exp.pop_front());
                end
                if (miso_obs.size() > 0) begin
                    checks++;
                    errors++;
                    $display("FAIL miso_byte unexpected: got %h expected nothing", miso_obs.pop_front());
                end
            end
        end
    end

    // Master model: mode 0, 4-cycle SCLK phases, MISO sampled at each SCLK rise
    task automatic spi_frame(input logic [7:0] mo, input int nbits, input bit start_cs,
                             input bit end_cs, input bit keep);
        logic [7:0] mi;
        mi = '0;
        if (start_cs) begin
            bus_if.cs_ni = 1'b0;
            repeat (6) @(negedge clk);
        end
        for (int i = 0; i < nbits; i++) begin
            bus_if.mosi_i = mo[7-i];
            repeat (4) @(negedge clk);
            mi[7-i] = bus_if.miso_o;
            bus_if.sclk_i = 1'b1;
            repeat (4) @(negedge clk);
            if (i == nbits - 1 && end_cs) begin
                bus_if.cs_ni = 1'b1;
                repeat (4) @(negedge clk);
            end
            bus_if.sclk_i = 1'b0;
        end
        repeat (4) @(negedge clk);
        if (keep) miso_obs.push_back(mi);
    endtask

    task automatic write_tx(input logic [7:0] b);
        check1("tx_ready_before_write", bus_if.tx_ready_o, 1'b1);
        bus_if.tx_data_i  = b;
        bus_if.tx_valid_i = 1'b1;
        @(negedge clk);
        bus_if.tx_valid_i = 1'b0;
        check1("tx_ready_after_write", bus_if.tx_ready_o, 1'b0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check1({tag, "_miso"},     bus_if.miso_o,        1'b0);
        check1({tag, "_miso_oe"},  bus_if.miso_oe_o,     1'b0);
        check8({tag, "_rx_data"},  bus_if.rx_data_o,     8'h00);
        check1({tag, "_rx_valid"}, bus_if.rx_valid_o,    1'b0);
        check1({tag, "_underrun"}, bus_if.tx_underrun_o, 1'b0);
        check1({tag, "_tx_ready"}, bus_if.tx_ready_o,    1'b1);
    endtask

    initial begin
        #(100 * 50000);
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n             = 1'b0;
        bus_if.sclk_i     = 1'b0;
        bus_if.cs_ni      = 1'b1;
        bus_if.mosi_i     = 1'b0;
        bus_if.tx_data_i  = '0;
        bus_if.tx_valid_i = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // Buffered byte goes out, received byte delivered once
        write_tx(8'hA5);
        rx_exp.push_back(8'h3C);
        miso_exp.push_back(8'hA5);
        spi_frame(8'h3C, 8, 1'b1, 1'b1, 1'b1);
        check1("tx_ready_after_load", bus_if.tx_ready_o, 1'b1);

        // Empty buffer: dummy byte with one underrun pulse
        urun_exp.push_back(1'b1);
        rx_exp.push_back(8'hFF);
        miso_exp.push_back(8'h00);
        spi_frame(8'hFF, 8, 1'b1, 1'b1, 1'b1);

        // Back-to-back frames under one chip select
        write_tx(8'hC3);
        rx_exp.push_back(8'h12);
        rx_exp.push_back(8'h34);
        miso_exp.push_back(8'hC3);
        miso_exp.push_back(8'h5A);
        bus_if.cs_ni = 1'b0;
        repeat (6) @(negedge clk);
        check1("miso_oe_selected", bus_if.miso_oe_o, 1'b1);
        write_tx(8'h5A);
        spi_frame(8'h12, 8, 1'b0, 1'b0, 1'b1);
        spi_frame(8'h34, 8, 1'b0, 1'b1, 1'b1);
        check1("miso_oe_deselected", bus_if.miso_oe_o, 1'b0);
        check1("tx_ready_after_b2b", bus_if.tx_ready_o, 1'b1);

        // Abort after 5 rises: no rx, buffered byte survives
        urun_exp.push_back(1'b1);
        bus_if.cs_ni = 1'b0;
        repeat (6) @(negedge clk);
        write_tx(8'h81);
        spi_frame(8'hA7, 5, 1'b0, 1'b1, 1'b0);
        check1("tx_ready_after_abort", bus_if.tx_ready_o, 1'b0);
        rx_exp.push_back(8'h5C);
        miso_exp.push_back(8'h81);
        spi_frame(8'h5C, 8, 1'b1, 1'b1, 1'b1);
        check1("tx_ready_after_abort_reuse", bus_if.tx_ready_o, 1'b1);

        // Async reset mid-frame with a byte buffered
        urun_exp.push_back(1'b1);
        bus_if.cs_ni = 1'b0;
        repeat (6) @(negedge clk);
        write_tx(8'h77);
        spi_frame(8'hE1, 3, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midframe_reset");
        @(negedge clk);
        bus_if.cs_ni = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        urun_exp.push_back(1'b1);
        rx_exp.push_back(8'h4B);
        miso_exp.push_back(8'h00);
        spi_frame(8'h4B, 8, 1'b1, 1'b1, 1'b1);

        // SCLK toggling while deselected must be ignored
        for (int i = 0; i < 10; i++) begin
            bus_if.mosi_i = i[0];
            bus_if.sclk_i = ~bus_if.sclk_i;
            repeat (4) @(negedge clk);
        end
        bus_if.sclk_i = 1'b0;
        repeat (4) @(negedge clk);

        // Write lands in the same cycle as the CS_n-fall load
        urun_exp.push_back(1'b1);
        rx_exp.push_back(8'h96);
        miso_exp.push_back(8'h00);
        bus_if.cs_ni = 1'b0;
        @(negedge clk);
        @(negedge clk);
        bus_if.tx_data_i  = 8'h3E;
        bus_if.tx_valid_i = 1'b1;
        @(negedge clk);
        bus_if.tx_valid_i = 1'b0;
        check1("tx_ready_coincident_write", bus_if.tx_ready_o, 1'b0);
        spi_frame(8'h96, 8, 1'b0, 1'b1, 1'b1);
        rx_exp.push_back(8'h69);
        miso_exp.push_back(8'h3E);
        spi_frame(8'h69, 8, 1'b1, 1'b1, 1'b1);
        check1("tx_ready_final", bus_if.tx_ready_o, 1'b1);

        repeat (10) @(negedge clk);
        check_int("rx_pending", rx_exp.size(), 0);
        check_int("miso_pending", miso_exp.size(), 0);
        check_int("underrun_pending", urun_exp.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
